// File: rtl/mcycle_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package mcycle_unit_pkg;

  typedef enum logic [1:0] {
    MC_MULU = 2'b00,
    MC_MULS = 2'b01,
    MC_DIVU = 2'b10,
    MC_DIVS = 2'b11
  } mcycle_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_COMPUTING = 2'b01,
    ST_DONE      = 2'b10
  } mcycle_state_e;

endpackage

// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider sharing one accumulator
// and one WIDTH+1-bit adder; stalls the pipeline via Busy until done.
module mcycle_unit
  import mcycle_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mcycle_state_e        state_q, state_d;
  logic                 div_q, div_d;
  logic                 sign1_q, sign1_d;
  logic                 sign2_q, sign2_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     res1_q, res1_d;
  logic [WIDTH-1:0]     res2_q, res2_d;

  mcycle_op_e           op_in;
  logic                 in_div, in_signed, in_s1, in_s2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       opa, opb, sum;
  logic [2*WIDTH-1:0]   iter_acc, prod;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    op_in     = mcycle_op_e'(MCycleOp);
    in_div    = (op_in == MC_DIVU) || (op_in == MC_DIVS);
    in_signed = (op_in == MC_MULS) || (op_in == MC_DIVS);
    in_s1     = in_signed & Operand1[WIDTH-1];
    in_s2     = in_signed & Operand2[WIDTH-1];
    mag1      = in_s1 ? -Operand1 : Operand1;
    mag2      = in_s2 ? -Operand2 : Operand2;

    // Divide widens the partial remainder by one bit (taken before the shift)
    // so the trial subtract never loses the bit shifted out of the top.
    opa = div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    opb = div_q ? ~{1'b0, b_q} : (acc_q[0] ? {1'b0, b_q} : '0);
    sum = opa + opb + {{WIDTH{1'b0}}, div_q};

    if (div_q)
      iter_acc = sum[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                            : {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      iter_acc = {sum, acc_q[WIDTH-1:1]};

    prod = (sign1_q ^ sign2_q) ? -iter_acc : iter_acc;
    quo  = iter_acc[WIDTH-1:0];
    rem  = iter_acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          div_d   = in_div;
          sign1_d = in_s1;
          sign2_d = in_s2;
          b_d     = in_div ? mag2 : mag1;
          acc_d   = {{WIDTH{1'b0}}, (in_div ? mag1 : mag2)};
          cnt_d   = '0;
          state_d = ST_COMPUTING;
        end
      end
      ST_COMPUTING: begin
        acc_d = iter_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          if (div_q) begin
            // With a zero divisor every trial subtract succeeds, leaving the
            // dividend magnitude as remainder; re-signing it restores the raw input.
            res1_d = (b_q == '0) ? '1 : ((sign1_q ^ sign2_q) ? -quo : quo);
            res2_d = sign1_q ? -rem : rem;
          end else begin
            res1_d = prod[WIDTH-1:0];
            res2_d = prod[2*WIDTH-1:WIDTH];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      div_q   <= 1'b0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end

  assign Busy    = (state_q == ST_COMPUTING) || ((state_q == ST_IDLE) && Start && !Reset);
  assign Result1 = res1_q;
  assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed self-checking bench for mcycle_unit (WIDTH = 32).
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  MCycleOp = 2'b00;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [31:0] Result1, Result2;
  logic        Busy;

  int n_cmp = 0;
  int n_err = 0;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Issues one operation at the next negedge and returns what is seen in DONE.
  // Operands are scrambled after the start edge; busy_n counts Busy-high cycles.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, output logic [31:0] r1, output logic [31:0] r2,
                       output int busy_n);
    @(negedge CLK);
    MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
    #1 busy_n = Busy ? 1 : 0;
    @(posedge CLK);
    #1;
    if (!hold) Start = 1'b0;
    Operand1 = ~a; Operand2 = b ^ 32'h5A5A5A5A; MCycleOp = ~op;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (Busy) busy_n++;
      else break;
    end
    r1 = Result1;
    r2 = Result2;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (Result1 !== 32'h0) begin n_err++; $display("FAIL reset_r1: got %h want 00000000", Result1); end
    n_cmp++; if (Result2 !== 32'h0) begin n_err++; $display("FAIL reset_r2: got %h want 00000000", Result2); end
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r1, r2; int bn;
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r1, r2, bn);
    n_cmp++; if (bn !== 33) begin n_err++; $display("FAIL mulu_busy: got %0d want 33", bn); end
    n_cmp++; if (r1 !== 32'h00000001) begin n_err++; $display("FAIL mulu_lo: got %h want 00000001", r1); end
    n_cmp++; if (r2 !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mulu_hi: got %h want fffffffe", r2); end
    do_op(2'b01, 32'hFFFFFFFD, 32'd5, 1'b0, r1, r2, bn);
    n_cmp++; if (r1 !== 32'hFFFFFFF1) begin n_err++; $display("FAIL muls_lo: got %h want fffffff1", r1); end
    n_cmp++; if (r2 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL muls_hi: got %h want ffffffff", r2); end
    do_op(2'b00, 32'h00010000, 32'h00010000, 1'b0, r1, r2, bn);
    n_cmp++; if ({r2, r1} !== 64'h00000001_00000000) begin n_err++; $display("FAIL mulu_2p32: got %h%h want 0000000100000000", r2, r1); end
    // Results must hold through idle cycles.
    repeat (3) @(negedge CLK);
    n_cmp++; if (Result2 !== 32'h1) begin n_err++; $display("FAIL hold_r2: got %h want 00000001", Result2); end
  endtask

  task automatic test_div();
    logic [31:0] r1, r2; int bn;
    do_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, r1, r2, bn);
    n_cmp++; if (r1 !== 32'hFFFFFFFD) begin n_err++; $display("FAIL divs_q: got %h want fffffffd", r1); end
    n_cmp++; if (r2 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divs_r: got %h want ffffffff", r2); end
    do_op(2'b10, 32'd100, 32'd7, 1'b0, r1, r2, bn);
    n_cmp++; if (bn !== 33) begin n_err++; $display("FAIL divu_busy: got %0d want 33", bn); end
    n_cmp++; if (r1 !== 32'd14) begin n_err++; $display("FAIL divu_q: got %h want 0000000e", r1); end
    n_cmp++; if (r2 !== 32'd2) begin n_err++; $display("FAIL divu_r: got %h want 00000002", r2); end
    do_op(2'b11, 32'd7, 32'hFFFFFFFE, 1'b0, r1, r2, bn);
    n_cmp++; if ({r1, r2} !== {32'hFFFFFFFD, 32'h1}) begin n_err++; $display("FAIL divs_pos_neg: got %h/%h want fffffffd/00000001", r1, r2); end
  endtask

  task automatic test_boundaries();
    logic [31:0] r1, r2; int bn;
    do_op(2'b10, 32'd5, 32'd0, 1'b0, r1, r2, bn);
    n_cmp++; if (bn !== 33) begin n_err++; $display("FAIL divz_busy: got %0d want 33", bn); end
    n_cmp++; if (r1 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divuz_q: got %h want ffffffff", r1); end
    n_cmp++; if (r2 !== 32'd5) begin n_err++; $display("FAIL divuz_r: got %h want 00000005", r2); end
    do_op(2'b11, 32'hFFFFFFFB, 32'd0, 1'b0, r1, r2, bn);
    n_cmp++; if (r1 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divsz_q: got %h want ffffffff", r1); end
    n_cmp++; if (r2 !== 32'hFFFFFFFB) begin n_err++; $display("FAIL divsz_r: got %h want fffffffb", r2); end
    do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, r1, r2, bn);
    n_cmp++; if (r1 !== 32'h80000000) begin n_err++; $display("FAIL ovf_q: got %h want 80000000", r1); end
    n_cmp++; if (r2 !== 32'h0) begin n_err++; $display("FAIL ovf_r: got %h want 00000000", r2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; int bn;
    do_op(2'b01, 32'h80000000, 32'h80000000, 1'b0, r1, r2, bn);
    n_cmp++; if ({r2, r1} !== 64'h40000000_00000000) begin n_err++; $display("FAIL muls_min: got %h%h want 4000000000000000", r2, r1); end
    do_op(2'b10, 32'hFFFFFFFF, 32'h00010000, 1'b0, r1, r2, bn);
    n_cmp++; if (bn !== 33) begin n_err++; $display("FAIL b2b_busy: got %0d want 33", bn); end
    n_cmp++; if ({r1, r2} !== {32'h0000FFFF, 32'h0000FFFF}) begin n_err++; $display("FAIL b2b_div: got %h/%h want 0000ffff/0000ffff", r1, r2); end
  endtask

  task automatic test_hold_start();
    logic [31:0] r1, r2; int bn;
    do_op(2'b00, 32'd3, 32'd4, 1'b1, r1, r2, bn);
    n_cmp++; if (bn !== 33) begin n_err++; $display("FAIL hold_busy: got %0d want 33", bn); end
    n_cmp++; if (r1 !== 32'd12) begin n_err++; $display("FAIL hold_res: got %h want 0000000c", r1); end
    // Start still high across the DONE edge, dropped right after it.
    @(posedge CLK);
    #1 Start = 1'b0;
    @(negedge CLK);
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL no_reaccept: got %b want 0", Busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r1, r2; int bn;
    @(negedge CLK);
    MCycleOp = 2'b00; Operand1 = 32'd9; Operand2 = 32'd9; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 Reset = 1'b1;
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", Busy); end
    n_cmp++; if ({Result1, Result2} !== 64'h0) begin n_err++; $display("FAIL mid_reset_res: got %h/%h want 0/0", Result1, Result2); end
    @(negedge CLK);
    Reset = 1'b0;
    do_op(2'b10, 32'd100, 32'd7, 1'b0, r1, r2, bn);
    n_cmp++; if (bn !== 33) begin n_err++; $display("FAIL restart_busy: got %0d want 33", bn); end
    n_cmp++; if ({r1, r2} !== {32'd14, 32'd2}) begin n_err++; $display("FAIL restart_res: got %h/%h want 0000000e/00000002", r1, r2); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_boundaries();
    test_back_to_back();
    test_hold_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
